// File: rtl/systolic_array_os_pkg.sv
// systolic_array_os_pkg: controller states and product-width helper shared by the array and its PEs
package systolic_array_os_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic int prod_width(input int ip_width);
    return 2 * ip_width;
  endfunction
endpackage

// File: rtl/systolic_pe_os.sv
// systolic_pe_os: output-stationary MAC cell; registers a right, b down, valid/clr right, accumulates a*b
// ports: a_in/b_in/valid_in/clr_in from left/top neighbour, *_out registered copies, acc the running sum
module systolic_pe_os
  import systolic_array_os_pkg::*;
#(
  parameter int ip_width = 8,
  parameter int op_width = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ip_width-1:0] a_in,
  input  logic [ip_width-1:0] b_in,
  input  logic                valid_in,
  input  logic                clr_in,
  output logic [ip_width-1:0] a_out,
  output logic [ip_width-1:0] b_out,
  output logic                valid_out,
  output logic                clr_out,
  output logic [op_width-1:0] acc
);
  localparam int pw = prod_width(ip_width);
  logic [ip_width-1:0] a_d, a_q, b_d, b_q;
  logic valid_d, valid_q, clr_d, clr_q;
  logic [op_width-1:0] acc_d, acc_q;
  logic signed [pw-1:0] prod;
  always_comb begin
    prod = pw'($signed(a_in)) * pw'($signed(b_in));
    a_d = a_in;
    b_d = b_in;
    valid_d = valid_in;
    clr_d = clr_in;
    acc_d = !valid_in ? acc_q : clr_in ? op_width'(prod) : acc_q + op_width'(prod);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      valid_q <= 1'b0;
      clr_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      valid_q <= valid_d;
      clr_q <= clr_d;
      acc_q <= acc_d;
    end
  assign a_out = a_q;
  assign b_out = b_q;
  assign valid_out = valid_q;
  assign clr_out = clr_q;
  assign acc = acc_q;
endmodule

// File: rtl/systolic_array_os.sv
// systolic_array_os: rows x cols output-stationary systolic matrix multiplier with job controller
// ports: en/clr token valid and first-token marker, input_matrix A column, weight_matrix B row,
//        compute_done result stable, cycles_count job length, output_matrix flattened C
module systolic_array_os
  import systolic_array_os_pkg::*;
#(
  parameter int rows = 64,
  parameter int cols = 64,
  parameter int ip_width = 8,
  parameter int op_width = 48
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [rows*ip_width-1:0]      input_matrix,
  input  logic [cols*ip_width-1:0]      weight_matrix,
  output logic                          compute_done,
  output logic [31:0]                   cycles_count,
  output logic [rows*cols*op_width-1:0] output_matrix
);
  localparam int drain_len = rows + cols - 2;
  logic [ip_width-1:0] a_w [rows][cols+1];
  logic v_w [rows][cols+1];
  logic c_w [rows][cols+1];
  logic [ip_width-1:0] b_w [rows+1][cols];
  // row lane i: A value plus valid/clr sideband, delayed i cycles
  for (genvar i = 0; i < rows; i++) begin : g_row
    logic [ip_width+1:0] lane_in, lane;
    assign lane_in = {en, clr, input_matrix[i*ip_width +: ip_width]};
    if (i == 0) begin : g_pass
      assign lane = lane_in;
    end else begin : g_skew
      logic [ip_width+1:0] sk_d [i];
      logic [ip_width+1:0] sk_q [i];
      always_comb begin
        sk_d[0] = lane_in;
        for (int n = 1; n < i; n++) sk_d[n] = sk_q[n-1];
      end
      always_ff @(posedge clk or negedge rst)
        if (!rst) sk_q <= '{default: '0};
        else sk_q <= sk_d;
      assign lane = sk_q[i-1];
    end
    assign {v_w[i][0], c_w[i][0], a_w[i][0]} = lane;
  end
  // column lane j: B value delayed j cycles
  for (genvar j = 0; j < cols; j++) begin : g_col
    logic [ip_width-1:0] lane_in;
    assign lane_in = weight_matrix[j*ip_width +: ip_width];
    if (j == 0) begin : g_pass
      assign b_w[0][j] = lane_in;
    end else begin : g_skew
      logic [ip_width-1:0] sk_d [j];
      logic [ip_width-1:0] sk_q [j];
      always_comb begin
        sk_d[0] = lane_in;
        for (int n = 1; n < j; n++) sk_d[n] = sk_q[n-1];
      end
      always_ff @(posedge clk or negedge rst)
        if (!rst) sk_q <= '{default: '0};
        else sk_q <= sk_d;
      assign b_w[0][j] = sk_q[j-1];
    end
  end
  for (genvar i = 0; i < rows; i++) begin : g_pe_r
    for (genvar j = 0; j < cols; j++) begin : g_pe_c
      systolic_pe_os #(.ip_width(ip_width), .op_width(op_width)) u_pe (
        .clk(clk),
        .rst(rst),
        .a_in(a_w[i][j]),
        .b_in(b_w[i][j]),
        .valid_in(v_w[i][j]),
        .clr_in(c_w[i][j]),
        .a_out(a_w[i][j+1]),
        .b_out(b_w[i+1][j]),
        .valid_out(v_w[i][j+1]),
        .clr_out(c_w[i][j+1]),
        .acc(output_matrix[(i*cols+j)*op_width +: op_width])
      );
    end
  end
  state_e state_d, state_q;
  logic [31:0] drain_d, drain_q, cyc_d, cyc_q;
  logic done_d, done_q;
  // drain covers the skew so the far corner PE has absorbed the last token before done
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cyc_d = cyc_q;
    done_d = done_q;
    case (state_q)
      IDLE, DONE: if (en && clr) begin
        state_d = RUN;
        cyc_d = 32'd1;
        done_d = 1'b0;
      end
      RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (!en) begin
          state_d = drain_len == 0 ? DONE : DRAIN;
          done_d = drain_len == 0;
          drain_d = 32'(drain_len);
        end
      end
      DRAIN: begin
        cyc_d = cyc_q + 32'd1;
        drain_d = drain_q - 32'd1;
        if (drain_q == 32'd1) begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      cyc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cyc_q <= cyc_d;
      done_q <= done_d;
    end
  assign compute_done = done_q;
  assign cycles_count = cyc_q;
endmodule

// File: tb/tb_systolic_array_os.sv
// tb_systolic_array_os: 1x1, 2x2 and 64x64 arrays share one token stream, checked against a matrix-product model
module tb_systolic_array_os;
  localparam int iw = 8;
  localparam int ow = 48;
  localparam int n = 64;
  localparam int kmax = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [n*iw-1:0] a_v = '0;
  logic [n*iw-1:0] b_v = '0;
  logic [n*n*ow-1:0] o64;
  logic [4*ow-1:0] o2;
  logic [ow-1:0] o1;
  logic dn [3];
  logic [31:0] cy [3];
  int a_m [n][kmax];
  int b_m [kmax][n];
  int sz [3] = '{1, 2, 64};
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  systolic_array_os #(.rows(1), .cols(1), .ip_width(iw), .op_width(ow)) d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .input_matrix(a_v[iw-1:0]), .weight_matrix(b_v[iw-1:0]),
    .compute_done(dn[0]), .cycles_count(cy[0]), .output_matrix(o1)
  );
  systolic_array_os #(.rows(2), .cols(2), .ip_width(iw), .op_width(ow)) d2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .input_matrix(a_v[2*iw-1:0]), .weight_matrix(b_v[2*iw-1:0]),
    .compute_done(dn[1]), .cycles_count(cy[1]), .output_matrix(o2)
  );
  systolic_array_os #(.rows(n), .cols(n), .ip_width(iw), .op_width(ow)) d64 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .input_matrix(a_v), .weight_matrix(b_v),
    .compute_done(dn[2]), .cycles_count(cy[2]), .output_matrix(o64)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_c(input int i, input int j, input int k_len);
    longint s = 0;
    for (int k = 0; k < k_len; k++) s += longint'(a_m[i][k]) * longint'(b_m[k][j]);
    return 64'(s) & 64'hFFFF_FFFF_FFFF;
  endfunction
  task automatic fill(input int av, input int bv, input bit rnd);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < kmax; k++) begin
        a_m[i][k] = rnd ? int'($urandom_range(255)) - 128 : av;
        b_m[k][i] = rnd ? int'($urandom_range(255)) - 128 : bv;
      end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_o64"}, 64'(|o64), 64'd0);
    chk({tag, "_o2"}, 64'(|o2), 64'd0);
    chk({tag, "_o1"}, 64'(|o1), 64'd0);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_done%0d", tag, d), 64'(dn[d]), 64'd0);
      chk($sformatf("%s_cyc%0d", tag, d), 64'(cy[d]), 64'd0);
    end
  endtask
  task automatic drive(input int k_len);
    for (int k = 0; k <= k_len; k++) begin
      @(negedge clk);
      if (k == 1)
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("start_done%0d", d), 64'(dn[d]), 64'd0);
          chk($sformatf("start_cyc%0d", d), 64'(cy[d]), 64'd1);
        end
      en = k < k_len;
      clr = k == 0;
      for (int i = 0; i < n; i++)
        if (k < k_len) begin
          a_v[i*iw +: iw] = iw'(a_m[i][k]);
          b_v[i*iw +: iw] = iw'(b_m[k][i]);
        end else begin
          a_v[i*iw +: iw] = '0;
          b_v[i*iw +: iw] = '0;
        end
    end
  endtask
  task automatic run_job(input int k_len);
    int first [3];
    int cat [3];
    int e;
    drive(k_len);
    first = '{-1, -1, -1};
    cat = '{0, 0, 0};
    e = k_len - 1;
    for (int t = 0; t < 400 && (first[0] < 0 || first[1] < 0 || first[2] < 0); t++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (dn[d] && first[d] < 0) begin
          first[d] = e;
          cat[d] = int'(cy[d]);
        end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("k%0d_done_edge%0d", k_len, d), 64'(first[d]), 64'(k_len + 2*sz[d] - 2));
      chk($sformatf("k%0d_cyc_at_done%0d", k_len, d), 64'(cat[d]), 64'(k_len + 2*sz[d] - 1));
      chk($sformatf("k%0d_done_hold%0d", k_len, d), 64'(dn[d]), 64'd1);
      chk($sformatf("k%0d_cyc_hold%0d", k_len, d), 64'(cy[d]), 64'(k_len + 2*sz[d] - 1));
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        logic [63:0] r;
        r = ref_c(i, j, k_len);
        chk($sformatf("k%0d_c64[%0d][%0d]", k_len, i, j), {16'd0, o64[(i*n+j)*ow +: ow]}, r);
        if (i < 2 && j < 2) chk($sformatf("k%0d_c2[%0d][%0d]", k_len, i, j), {16'd0, o2[(i*2+j)*ow +: ow]}, r);
        if (i == 0 && j == 0) chk($sformatf("k%0d_c1", k_len), {16'd0, o1}, r);
      end
  endtask
  initial begin
    #1 rst = 1'b0;
    #1 chk_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fill(0, 0, 1'b1);
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    run_job(2);
    chk("small_c00", {16'd0, o2[0*ow +: ow]}, 64'd19);
    chk("small_c01", {16'd0, o2[1*ow +: ow]}, 64'd22);
    chk("small_c10", {16'd0, o2[2*ow +: ow]}, 64'd43);
    chk("small_c11", {16'd0, o2[3*ow +: ow]}, 64'd50);
    fill(0, 0, 1'b1);
    run_job(128);
    fill(-128, -128, 1'b0);
    run_job(3);
    chk("neg_c00", {16'd0, o2[0 +: ow]}, 64'd49152);
    fill(1, 1, 1'b0);
    run_job(1);
    chk("ones_c11", {16'd0, o2[3*ow +: ow]}, 64'd1);
    fill(1, 1, 1'b0);
    drive(4);
    @(posedge clk);
    @(negedge clk);
    chk("drain_cyc2", 64'(cy[1]), 64'd5);
    chk("drain_done2", 64'(dn[1]), 64'd0);
    chk("drain_done1", 64'(dn[0]), 64'd1);
    #2 rst = 1'b0;
    #1 chk_idle_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    clr = 1'b0;
    a_v = {16{$urandom()}};
    b_v = {16{$urandom()}};
    @(negedge clk);
    en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("idle_noclr_done%0d", d), 64'(dn[d]), 64'd0);
      chk($sformatf("idle_noclr_cyc%0d", d), 64'(cy[d]), 64'd0);
    end
    fill(0, 0, 1'b1);
    a_m[0][0] = -3;
    b_m[0][0] = 7;
    run_job(1);
    chk("neg_c1", {16'd0, o1}, 64'hFFFF_FFFF_FFEB);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
